demux_1to2_stream: RTL and testbench
====================================

DEMUX_1TO2_STREAM -- requirements
Module: demux_1to2_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_data, input, WIDTH bits, the input beat payload.
REQ-005 The block SHALL have port in_sel, input, 1 bit, the destination select (0 = out0, 1 = out1), used when alt_en=0.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the input beat is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the beat this cycle.
REQ-008 The block SHALL have port alt_en, input, 1 bit, which enables alternating-destination mode.
REQ-009 The block SHALL have ports out0_data and out1_data, outputs, WIDTH bits each, the registered channel payloads.
REQ-010 The block SHALL have ports out0_valid and out1_valid, outputs, 1 bit each, meaning the channel holds a beat.
REQ-011 The block SHALL have ports out0_ready and out1_ready, inputs, 1 bit each, the downstream accept signals.
REQ-012 The block SHALL have ports cnt0 and cnt1, outputs, 8 bits each, the accepted-beat counts per channel.

Function
REQ-013 The block SHALL compute dest = alt_ptr when alt_en=1, else dest = in_sel.
REQ-014 The block SHALL drive in_ready = !outX_valid || outX_ready, where X = dest; this path is combinational from outX_ready, alt_en, in_sel and registered state.
REQ-015 The block SHALL accept a beat in any cycle with in_valid && in_ready; in_ready SHALL NOT depend on in_valid.
REQ-016 On accept, the block SHALL load outX_data <= in_data and set outX_valid <= 1 at the next edge, giving 1-cycle latency.
REQ-017 The block SHALL clear outX_valid when outX_valid && outX_ready and the channel is not reloaded in the same cycle.
REQ-018 When a channel is drained and reloaded in the same cycle, the block SHALL set outX_data to the new beat and keep outX_valid at 1, so back-to-back beats reach full throughput.
REQ-019 The non-destination channel SHALL be unaffected by an accept; its valid and data evolve only per REQ-017.
REQ-020 The block SHALL hold outX_data while outX_valid=1 and outX_ready=0, and SHALL retain the last value when outX_valid=0.
REQ-021 The alternation state alt_ptr (1 bit) SHALL be forced to 0 while alt_en=0, and SHALL toggle on each accepted beat while alt_en=1.
REQ-022 Alternation SHALL stall without advancing when the current alt_ptr channel is full and not draining, even if the other channel is empty.
REQ-023 The block SHALL increment cnt0 or cnt1 by 1 for each beat accepted to the respective channel, wrapping 255 -> 0.
REQ-024 The block SHALL never drop or duplicate a beat: every accepted beat appears exactly once on exactly one channel, and each channel preserves order.

Reset
REQ-025 While rst_n=0 at an edge, the block SHALL set out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0 and alt_ptr=0.
REQ-026 During reset, in_ready SHALL be ignored by upstream; no beat SHALL be accepted or counted on a reset edge.
REQ-027 Reset asserted mid-operation SHALL discard pending channel beats; both valids SHALL read 0 on the cycle after the reset edge.
REQ-028 The block SHALL place no asynchronous path from rst_n to any register.

Verification
REQ-029 The bench SHALL check select routing: alt_en=0, in_sel=1, in_data=8'hA5, in_valid=1, out1_ready=1 for one cycle -> next cycle out1_valid=1, out1_data=A5, out0_valid=0, cnt1=1.
REQ-030 The bench SHALL check backpressure: out0_ready=0 with two beats 11, 22 to out0 -> 11 held on out0, in_ready=0 for the second beat; after out0_ready=1, 22 follows the next cycle; cnt0=2.
REQ-031 The bench SHALL check alternation: alt_en=1, both readies=1, beats 01..04 back-to-back -> out0 gets 01, 03 and out1 gets 02, 04 at one beat per cycle; cnt0=2, cnt1=2.
REQ-032 The bench SHALL check alternation stall: alt_en=1, out0 full, out0_ready=0, alt_ptr=0 -> in_ready=0 although out1 is empty; no counter changes.
REQ-033 The bench SHALL check wrap: 256 beats to out1 -> cnt1=0, and cnt0 is unchanged.
REQ-034 The bench SHALL check reset mid-stream: rst_n=0 for one edge while both channels are valid -> both valids=0, counters=0, and the next accepted beat goes to out0 in alternating mode.

Source files
------------

// File: rtl/demux_1to2_stream_if.sv
// demux_1to2_stream_if: stream bundle between an upstream source, the 1-to-2 demux and two downstream sinks
// master: upstream/sink side (drives in_*, alt_en, outX_ready); slave: demux side (drives in_ready, outX_*, cnt*)
interface demux_1to2_stream_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic             alt_en;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic             out0_valid;
  logic             out1_valid;
  logic             out0_ready;
  logic             out1_ready;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;
  modport master (
    output in_data, in_sel, in_valid, alt_en, out0_ready, out1_ready,
    input  in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
  );
  modport slave (
    input  in_data, in_sel, in_valid, alt_en, out0_ready, out1_ready,
    output in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: routes an input stream into two registered output channels by select or alternation
// clk: clock; rst_n: synchronous active-low reset; s: stream bundle (slave view)
module demux_1to2_stream #(parameter int WIDTH = 8) (
  input logic                 clk,
  input logic                 rst_n,
  demux_1to2_stream_if.slave  s
);
  logic alt_ptr, dest, acc, ld0, ld1;
  always_comb begin
    dest       = s.alt_en ? alt_ptr : s.in_sel;
    // a slot is free if empty or being drained this cycle; in_valid is deliberately not involved
    s.in_ready = dest ? (!s.out1_valid || s.out1_ready) : (!s.out0_valid || s.out0_ready);
    acc        = s.in_valid && s.in_ready;
    ld0        = acc && !dest;
    ld1        = acc && dest;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s.out0_valid <= 1'b0;
      s.out1_valid <= 1'b0;
      s.out0_data  <= '0;
      s.out1_data  <= '0;
      s.cnt0       <= '0;
      s.cnt1       <= '0;
      alt_ptr      <= 1'b0;
    end else begin
      if (ld0) begin
        s.out0_data  <= s.in_data;
        s.out0_valid <= 1'b1;
        s.cnt0       <= s.cnt0 + 8'd1;
      end else if (s.out0_ready) s.out0_valid <= 1'b0;
      if (ld1) begin
        s.out1_data  <= s.in_data;
        s.out1_valid <= 1'b1;
        s.cnt1       <= s.cnt1 + 8'd1;
      end else if (s.out1_ready) s.out1_valid <= 1'b0;
      alt_ptr <= s.alt_en ? alt_ptr ^ acc : 1'b0;
    end
  end
endmodule

// File: tb/tb_demux_1to2_stream.sv
// tb_demux_1to2_stream: directed and randomized checks of demux_1to2_stream against a slot-level model
module tb_demux_1to2_stream;
  logic clk = 1'b0;
  logic rst_n;
  int nvec = 0;
  int nerr = 0;
  demux_1to2_stream_if #(.WIDTH(8)) bus();
  demux_1to2_stream #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;
  bit       m_v[2];
  bit [7:0] m_d[2];
  int       m_cnt[2];
  bit       m_ap;
  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic cycle(input bit v, input bit sel, input bit [7:0] data, input bit alt,
                       input bit r0, input bit r1, input bit rn);
    bit d, rdy, acc;
    bit r[2];
    rst_n = rn;
    bus.in_valid = v;
    bus.in_sel = sel;
    bus.in_data = data;
    bus.alt_en = alt;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    r[0] = r0;
    r[1] = r1;
    d = alt ? m_ap : sel;
    rdy = !m_v[d] || r[d];
    #1;
    if (rn) chk("in_ready", int'(bus.in_ready), int'(rdy));
    chk("out0_valid", int'(bus.out0_valid), int'(m_v[0]));
    chk("out1_valid", int'(bus.out1_valid), int'(m_v[1]));
    chk("out0_data", int'(bus.out0_data), int'(m_d[0]));
    chk("out1_data", int'(bus.out1_data), int'(m_d[1]));
    chk("cnt0", int'(bus.cnt0), m_cnt[0]);
    chk("cnt1", int'(bus.cnt1), m_cnt[1]);
    if (!rn) begin
      m_v = '{0, 0};
      m_d = '{0, 0};
      m_cnt = '{0, 0};
      m_ap = 0;
    end else begin
      acc = v && rdy;
      for (int c = 0; c < 2; c++) begin
        if (m_v[c] && r[c]) m_v[c] = 0;
        if (acc && d == c[0]) begin
          m_v[c] = 1;
          m_d[c] = data;
          m_cnt[c] = (m_cnt[c] + 1) % 256;
        end
      end
      m_ap = alt ? m_ap ^ acc : 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int c0;
    int c1;
    m_v = '{0, 0};
    m_d = '{0, 0};
    m_cnt = '{0, 0};
    m_ap = 0;
    rst_n = 0;
    bus.in_valid = 0;
    bus.in_sel = 0;
    bus.in_data = 0;
    bus.alt_en = 0;
    bus.out0_ready = 0;
    bus.out1_ready = 0;
    @(posedge clk);
    #1;
    cycle(0, 0, 8'h00, 0, 0, 0, 0);
    chk("rst_v0", int'(bus.out0_valid), 0);
    chk("rst_cnt1", int'(bus.cnt1), 0);
    cycle(1, 1, 8'hA5, 0, 0, 1, 1);
    chk("sel_v1", int'(bus.out1_valid), 1);
    chk("sel_d1", int'(bus.out1_data), 'hA5);
    chk("sel_v0", int'(bus.out0_valid), 0);
    chk("sel_cnt1", int'(bus.cnt1), 1);
    cycle(0, 0, 8'h00, 0, 1, 1, 1);
    cycle(1, 0, 8'h11, 0, 0, 1, 1);
    cycle(1, 0, 8'h22, 0, 0, 1, 1);
    chk("bp_rdy", int'(bus.in_ready), 0);
    chk("bp_hold", int'(bus.out0_data), 'h11);
    chk("bp_cnt0", int'(bus.cnt0), 1);
    cycle(1, 0, 8'h22, 0, 1, 1, 1);
    chk("bp_next", int'(bus.out0_data), 'h22);
    chk("bp_v0", int'(bus.out0_valid), 1);
    chk("bp_cnt0b", int'(bus.cnt0), 2);
    cycle(0, 0, 8'h00, 0, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 8'(i + 1), 1, 1, 1, 1);
      chk("alt_d", int'(i % 2 ? bus.out1_data : bus.out0_data), i + 1);
      chk("alt_v", int'(i % 2 ? bus.out1_valid : bus.out0_valid), 1);
    end
    chk("alt_cnt0", int'(bus.cnt0), 2);
    chk("alt_cnt1", int'(bus.cnt1), 2);
    cycle(1, 0, 8'h55, 1, 0, 1, 1);
    cycle(1, 0, 8'h66, 1, 0, 1, 1);
    cycle(1, 0, 8'h77, 1, 0, 1, 1);
    c0 = int'(bus.cnt0);
    c1 = int'(bus.cnt1);
    cycle(1, 0, 8'h77, 1, 0, 1, 1);
    chk("stall_rdy", int'(bus.in_ready), 0);
    chk("stall_v1", int'(bus.out1_valid), 0);
    chk("stall_cnt0", int'(bus.cnt0), c0);
    chk("stall_cnt1", int'(bus.cnt1), c1);
    cycle(0, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      cycle(1, 1, 8'(i), 0, 0, 1, 1);
      if (i == 254) chk("wrap_255", int'(bus.cnt1), 255);
    end
    chk("wrap_cnt1", int'(bus.cnt1), 0);
    chk("wrap_cnt0", int'(bus.cnt0), 0);
    cycle(1, 0, 8'hAA, 0, 0, 0, 1);
    cycle(1, 1, 8'hBB, 0, 0, 0, 1);
    chk("mid_both", int'(bus.out0_valid & bus.out1_valid), 1);
    cycle(1, 1, 8'hEE, 1, 0, 0, 0);
    chk("mid_v0", int'(bus.out0_valid), 0);
    chk("mid_v1", int'(bus.out1_valid), 0);
    chk("mid_cnt", int'(bus.cnt0) + int'(bus.cnt1), 0);
    cycle(1, 1, 8'hCC, 1, 1, 1, 1);
    chk("mid_d0", int'(bus.out0_data), 'hCC);
    chk("mid_v1b", int'(bus.out1_valid), 0);
    chk("mid_cnt0", int'(bus.cnt0), 1);
    for (int i = 0; i < 600; i++)
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom), 8'($urandom), bit'($urandom_range(0, 2) != 0),
            bit'($urandom), bit'($urandom), bit'($urandom_range(0, 49) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
